multi_channel_capture_ip: RTL and testbench

Parametrised N-channel capture block. Each input channel carries a valid/ready data stream. A round-robin arbiter merges the channels into one registered output stream tagged with the source channel index. A wrapping beat counter tracks delivered beats. The block is the well-formed, parametrised successor to the single-channel test IP and is used as a clean SDC-promotion target with real sequential paths.

---
 rtl/multi_channel_capture_ip.sv | 90 +++++++++
 tb/tb_multi_channel_capture_ip.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_capture_ip.sv
// rtl/multi_channel_capture_ip.sv - N-channel round-robin capture into one registered, channel-tagged stream
// Optional out_parity output when CAPTURE_PARITY_EN is defined.
module multi_channel_capture_ip #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [CHANNELS-1:0]        in_valid,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic [CHANNELS-1:0]        in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [CH_W-1:0]            out_chan,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           beat_count
`ifdef CAPTURE_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   next_ptr;
    logic              grant_any;
    logic              load;
    logic              accept;
    logic [DATA_W-1:0] grant_data;

    assign load = ~out_valid | out_ready;

    // Scan from rr_ptr upward with wrap; the first valid channel wins.
    always_comb begin
        int idx;
        idx        = 0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_any && in_valid[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = CH_W'(idx);
                grant_data = in_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && en && load && grant_any)
            in_ready = CHANNELS'(1) << grant_idx;
    end

    assign accept   = |(in_valid & in_ready);
    assign next_ptr = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            rr_ptr     <= '0;
            beat_count <= '0;
`ifdef CAPTURE_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                rr_ptr    <= next_ptr;
`ifdef CAPTURE_PARITY_EN
                out_parity <= ^grant_data;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready)
                beat_count <= beat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_channel_capture_ip.sv
// tb/tb_multi_channel_capture_ip.sv - directed self-checking bench for multi_channel_capture_ip
module tb_multi_channel_capture_ip;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 4;
    localparam int CH_W     = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       en;
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [CHANNELS-1:0]        in_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_chan;
    logic                       out_ready;
    logic [CNT_W-1:0]           beat_count;
`ifdef CAPTURE_PARITY_EN
    logic                       out_parity;
`endif

    int vectors    = 0;
    int miscompares = 0;

    multi_channel_capture_ip #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .beat_count(beat_count)
`ifdef CAPTURE_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
        in_valid = 4'hF; in_data = 32'h1312_1110;
        after_edge();
        after_edge();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
        vectors++;
        if (beat_count !== 4'd0) begin miscompares++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
        vectors++;
        if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        in_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midstream();
        en = 1'b1; out_ready = 1'b0;
        in_valid = 4'b0010; in_data = 32'h0000_A500;
        @(negedge clk);
        vectors++;
        if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_in_ready got %b want 0010", in_ready); end
        after_edge();
        in_valid = '0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd1)
            begin miscompares++; $display("FAIL mid_capture got v=%0b d=%h c=%0d want v=1 d=a5 c=1", out_valid, out_data, out_chan); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || beat_count !== 4'd0)
            begin miscompares++; $display("FAIL async_reset got v=%0b d=%h c=%0d n=%0d want all 0", out_valid, out_data, out_chan, beat_count); end
        after_edge();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 4'b0100; in_data = 32'h003C_0000;
        @(negedge clk);
        vectors++;
        if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 0100", in_ready); end
        after_edge();
        in_valid = '0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 2'd2)
            begin miscompares++; $display("FAIL post_reset_beat got v=%0b d=%h c=%0d want v=1 d=3c c=2", out_valid, out_data, out_chan); end
        after_edge();
        vectors++;
        if (out_valid !== 1'b0 || beat_count !== 4'd1)
            begin miscompares++; $display("FAIL post_reset_drain got v=%0b n=%0d want v=0 n=1", out_valid, beat_count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 4'hF; in_data = 32'h1312_1110;
        for (int k = 1; k <= 5; k++) begin
            after_edge();
            vectors++;
            if (out_valid !== 1'b1 || out_chan !== 2'((k - 1) % 4) || out_data !== 8'(8'h10 + (k - 1) % 4)
                || beat_count !== 4'(k - 1))
                begin miscompares++; $display("FAIL rr_beat%0d got v=%0b c=%0d d=%h n=%0d want v=1 c=%0d d=%h n=%0d",
                    k, out_valid, out_chan, out_data, beat_count, (k - 1) % 4, 8'h10 + (k - 1) % 4, k - 1); end
        end
        in_valid = '0;
        after_edge();
        vectors++;
        if (out_valid !== 1'b0 || beat_count !== 4'd5)
            begin miscompares++; $display("FAIL rr_drain got v=%0b n=%0d want v=0 n=5", out_valid, beat_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 4'b1000; in_data = 32'h7E22_1100;
        after_edge();
        in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h7E || out_chan !== 2'd3 || in_ready !== 4'b0000)
                begin miscompares++; $display("FAIL bp_hold%0d got v=%0b d=%h c=%0d r=%b want v=1 d=7e c=3 r=0000",
                    k, out_valid, out_data, out_chan, in_ready); end
            after_edge();
        end
        in_valid = '0;
        out_ready = 1'b1;
        after_edge();
        vectors++;
        if (out_valid !== 1'b0 || beat_count !== 4'd6 || out_data !== 8'h7E)
            begin miscompares++; $display("FAIL bp_release got v=%0b n=%0d d=%h want v=0 n=6 d=7e", out_valid, beat_count, out_data); end
    endtask

    task automatic test_en_gating();
        en = 1'b0; out_ready = 1'b1;
        in_valid = 4'b0001; in_data = 32'h0000_005A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b0)
                begin miscompares++; $display("FAIL en_low%0d got r=%b v=%0b want r=0000 v=0", k, in_ready, out_valid); end
            after_edge();
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL en_high_ready got %b want 0001", in_ready); end
        after_edge();
        in_valid = '0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd0)
            begin miscompares++; $display("FAIL en_high_beat got v=%0b d=%h c=%0d want v=1 d=5a c=0", out_valid, out_data, out_chan); end
        after_edge();
        vectors++;
        if (beat_count !== 4'd7) begin miscompares++; $display("FAIL en_count got %0d want 7", beat_count); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0001; in_data = 32'h0000_0042;
        after_edge();
        for (int k = 1; k <= 17; k++) begin
            after_edge();
            if (k >= 15) begin
                vectors++;
                if (beat_count !== 4'(k % 16))
                    begin miscompares++; $display("FAIL wrap_%0d got %0d want %0d", k, beat_count, k % 16); end
            end
        end
        in_valid = '0;
        after_edge();
    endtask

`ifdef CAPTURE_PARITY_EN
    task automatic test_parity();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0001; in_data = 32'h0000_0007;
        after_edge();
        in_data = 32'h0000_0003;
        vectors++;
        if (out_parity !== 1'b1) begin miscompares++; $display("FAIL parity_07 got %0b want 1", out_parity); end
        after_edge();
        in_valid = '0;
        vectors++;
        if (out_parity !== 1'b0 || out_data !== 8'h03)
            begin miscompares++; $display("FAIL parity_03 got p=%0b d=%h want p=0 d=03", out_parity, out_data); end
        after_edge();
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midstream();
        test_round_robin();
        test_backpressure();
        test_en_gating();
        test_counter_wrap();
`ifdef CAPTURE_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
